fetch_queue: RTL

- Two-wide instruction fetch stage that sits directly upstream of decode.
- Owns a byte-addressed instruction memory read as big-endian words, {mem[a],mem[a+1],mem[a+2],mem[a+3]}, fetching at pc and pc+4.
- Buffers fetched instructions, each tagged with its PC, in a circular queue.
- Presents the two oldest entries to decode under a ready/valid handshake, stalling fetch on backpressure and halting on an all-zero terminator word.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_imem.sv | 35 +++
 rtl/fetch_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the two-wide fetch stage.
//   fetch_entry_t : one queued instruction tagged with its byte PC
//   fetch_state_e : fetch sequencer states
package fetch_queue_pkg;

  localparam int unsigned FETCH_WIDTH = 2;
  localparam int unsigned FQ_PC_W     = 7;

  typedef struct packed {
    logic [31:0]        instr;
    logic [FQ_PC_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_imem.sv
// Byte-addressed instruction memory with one byte write port and a
// combinational two-word big-endian read at raddr_i and raddr_i+4.
//   clk_i            : write clock
//   we_i/waddr_i/wdata_i : byte write port
//   raddr_i          : read byte address (word aligned)
//   word0_o/word1_o  : word(raddr_i), word(raddr_i+4)
module fetch_imem #(
  parameter int unsigned IMEM_BYTES = 128,
  parameter int unsigned PC_W       = 7
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [PC_W-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [PC_W-1:0] raddr_i,
  output logic [31:0]     word0_o,
  output logic [31:0]     word1_o
);

  logic [7:0] mem_q [IMEM_BYTES];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  function automatic logic [31:0] rd_word(input logic [PC_W-1:0] a);
    return {mem_q[a], mem_q[a + PC_W'(1)], mem_q[a + PC_W'(2)], mem_q[a + PC_W'(3)]};
  endfunction

  always_comb begin
    word0_o = rd_word(raddr_i);
    word1_o = rd_word(raddr_i + PC_W'(4));
  end

endmodule

// File: rtl/fetch_queue.sv
// Two-wide instruction fetch stage feeding decode.
// Fetches word(pc) and word(pc+4) into a circular queue of PC-tagged
// entries and presents the two oldest entries under a ready/valid handshake.
//   clk, rst (async, active-high), start : control
//   imem_we/imem_waddr/imem_wdata        : program load port
//   dec_ready                            : decode pops up to two entries
//   out_valid_*/out_instr_*/out_pc_*     : slot 1 (older), slot 2 (younger)
//   fetch_done, total_instr_count, q_count : status
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 128,
  parameter int unsigned QDEPTH     = 8,
  parameter int unsigned PC_W       = FQ_PC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      imem_we,
  input  logic [PC_W-1:0]           imem_waddr,
  input  logic [7:0]                imem_wdata,
  input  logic                      dec_ready,
  output logic                      out_valid_1,
  output logic [31:0]               out_instr_1,
  output logic [PC_W-1:0]           out_pc_1,
  output logic                      out_valid_2,
  output logic [31:0]               out_instr_2,
  output logic [PC_W-1:0]           out_pc_2,
  output logic                      fetch_done,
  output logic [31:0]               total_instr_count,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, free_slots;
  logic [31:0]      total_q, total_d;
  logic [1:0]       n_push, n_pop;
  logic             at_mem_end;
  logic [31:0]      w1, w2;
  fetch_entry_t     q_mem [QDEPTH];
  fetch_entry_t     ent1, ent2;

  fetch_imem #(
    .IMEM_BYTES(IMEM_BYTES),
    .PC_W      (PC_W)
  ) u_imem (
    .clk_i  (clk),
    .we_i   (imem_we),
    .waddr_i(imem_waddr),
    .wdata_i(imem_wdata),
    .raddr_i(pc_q),
    .word0_o(w1),
    .word1_o(w2)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    n_push     = 2'd0;
    free_slots = CNT_W'(QDEPTH) - count_q;
    // Widened compare so pc+8 == IMEM_BYTES is seen before pc would wrap.
    at_mem_end = ({1'b0, pc_q} + (PC_W+1)'(8)) == (PC_W+1)'(IMEM_BYTES);

    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (free_slots >= CNT_W'(FETCH_WIDTH)) begin
          if (w1 == '0) begin
            state_d = ST_DONE;
          end else if (w2 == '0) begin
            n_push  = 2'd1;
            state_d = ST_DONE;
          end else begin
            n_push = 2'd2;
            if (at_mem_end) state_d = ST_DONE;
            else            pc_d    = pc_q + PC_W'(8);
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    n_pop = 2'd0;
    if (dec_ready) begin
      if (count_q >= CNT_W'(2)) n_pop = 2'd2;
      else                      n_pop = {1'b0, count_q[0]};
    end

    count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_push);
    total_d = total_q + 32'(n_push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      total_q <= total_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0)
      q_mem[tail_q] <= '{instr: w1, pc: FQ_PC_W'(pc_q)};
    if (n_push == 2'd2)
      q_mem[tail_q + PTR_W'(1)] <= '{instr: w2, pc: FQ_PC_W'(pc_q + PC_W'(4))};
  end

  always_comb begin
    ent1        = q_mem[head_q];
    ent2        = q_mem[head_q + PTR_W'(1)];
    out_valid_1 = (count_q != '0);
    out_valid_2 = (count_q >= CNT_W'(2));
    out_instr_1 = out_valid_1 ? ent1.instr     : '0;
    out_pc_1    = out_valid_1 ? PC_W'(ent1.pc) : '0;
    out_instr_2 = out_valid_2 ? ent2.instr     : '0;
    out_pc_2    = out_valid_2 ? PC_W'(ent2.pc) : '0;
  end

  assign fetch_done        = (state_q == ST_DONE);
  assign total_instr_count = total_q;
  assign q_count           = count_q;

endmodule
